// File: rtl/mem_stream_reader.sv
// mem_stream_reader: sweeps a wrap-around address range over a combinational
// memory read port and returns the words as a valid/ready stream with last.
module mem_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH-1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   eff_len;
  logic [ADDR_WIDTH-1:0] next_ptr;
  logic                  load;
  logic                  drain;
  logic                  last_hs;

  assign eff_len  = (length > DEPTH_L) ? DEPTH_L : length;
  assign next_ptr = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
  assign load     = (!m_valid || m_ready) && (remaining != '0);
  assign drain    = m_ready && (remaining == '0);
  assign last_hs  = m_valid && m_ready && m_last;

  assign mem_read_addr = rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rd_ptr    <= base_addr;
            remaining <= eff_len;
            busy      <= 1'b1;
            if (eff_len == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // Output register refills whenever its current beat is gone.
          if (load) begin
            m_data    <= mem_read_data;
            m_valid   <= 1'b1;
            m_last    <= (remaining == CNT_ONE);
            rd_ptr    <= next_ptr;
            remaining <= remaining - CNT_ONE;
          end else if (drain) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
          if (last_hs) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
